int_mul_var_lat_param: RTL

- Parametrised variable-latency iterative integer multiplier with val/rdy request and response interfaces.
- Successor to the fixed 32-bit zero-skipping shift-add multiplier, which was unsigned and low-half only.
- Adds configurable operand width, a bounded multi-bit zero-skip per cycle, signed/unsigned mode, and low/high half result select.
- Used as a multiply unit behind a processor or accelerator front end.

---
 rtl/int_mul_var_lat_param_pkg.sv | 36 +++
 rtl/int_mul_var_lat_param_ctz_cap.sv | 29 ++
 rtl/int_mul_var_lat_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/int_mul_var_lat_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imul_pkg
// Description : Shared definitions for the variable-latency iterative
//               multiplier: default widths, state encoding and the
//               mux-select codes for the a, b and result datapath registers.
// Revision    : 1.0 - initial release
// ============================================================================
package imul_pkg;

  localparam int DEFAULT_NBITS     = 32;
  localparam int DEFAULT_SKIP_BITS = 4;

  // Control states
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // a_reg select
  localparam logic [1:0] A_SEL_HOLD  = 2'd0;
  localparam logic [1:0] A_SEL_LOAD  = 2'd1;
  localparam logic [1:0] A_SEL_SHIFT = 2'd2;

  // b_reg select
  localparam logic [1:0] B_SEL_HOLD  = 2'd0;
  localparam logic [1:0] B_SEL_LOAD  = 2'd1;
  localparam logic [1:0] B_SEL_SHIFT = 2'd2;

  // result select
  localparam logic [1:0] RES_SEL_HOLD  = 2'd0;
  localparam logic [1:0] RES_SEL_CLEAR = 2'd1;
  localparam logic [1:0] RES_SEL_ADD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/int_mul_var_lat_param_ctz_cap.sv
`default_nettype none
// ============================================================================
// Module      : int_mul_ctz_cap
// Description : Combinational trailing-zero count of an NBITS vector,
//               saturated at SKIP_BITS. Only the low SKIP_BITS bits are
//               inspected, so an all-zero low slice reports SKIP_BITS.
// Ports       : vec   in  NBITS  vector to scan
//               count out CW     min(ctz(vec), SKIP_BITS)
// Revision    : 1.0 - initial release
// ============================================================================
module int_mul_ctz_cap #(
  parameter int NBITS     = 32,
  parameter int SKIP_BITS = 4,
  localparam int CW       = $clog2(NBITS + 1)
) (
  input  logic [NBITS-1:0] vec,
  output logic [CW-1:0]    count
);

  // Scan from the top of the window downward so the lowest set bit wins.
  always_comb begin
    count = CW'(SKIP_BITS);
    for (int i = SKIP_BITS - 1; i >= 0; i--) begin
      if (vec[i]) count = CW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_mul_var_lat_param.sv
`default_nettype none
// ============================================================================
// Module      : int_mul_var_lat_param
// Description : Variable-latency iterative shift-add multiplier with bounded
//               multi-bit zero skipping, signed/unsigned operands and
//               low/high half result select. val/rdy on both sides.
// Ports       : clk            in   clock
//               reset          in   asynchronous active-high reset
//               req_val/rdy    in/out request handshake
//               req_msg_a/b    in   multiplicand / multiplier (NBITS)
//               req_msg_signed in   1 = two's complement operands
//               req_msg_hi     in   1 = return upper half of product
//               resp_val/rdy   out/in response handshake
//               resp_msg       out  selected half of product (NBITS)
// Revision    : 1.0 - initial release
// ============================================================================
module int_mul_var_lat_param
  import imul_pkg::*;
#(
  parameter int NBITS     = DEFAULT_NBITS,
  parameter int SKIP_BITS = DEFAULT_SKIP_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_msg_a,
  input  logic [NBITS-1:0] req_msg_b,
  input  logic             req_msg_signed,
  input  logic             req_msg_hi,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg
);

  localparam int CW = $clog2(NBITS + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [2*NBITS-1:0]   r_a;
  logic [2*NBITS-1:0]   r_result;
  logic [NBITS-1:0]     r_b;
  logic                 r_neg;
  logic                 r_hi;

  logic                 w_req_go;
  logic                 w_resp_go;
  logic                 w_b_zero;
  logic [1:0]           w_a_sel;
  logic [1:0]           w_b_sel;
  logic [1:0]           w_res_sel;
  logic [CW-1:0]        w_ctz;
  logic [CW-1:0]        w_shamt;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [NBITS-1:0]     w_a_mag;
  logic [NBITS-1:0]     w_b_mag;
  logic [2*NBITS-1:0]   w_final;

  assign req_rdy   = (r_state == ST_IDLE) && !reset;
  assign resp_val  = (r_state == ST_DONE);
  assign w_req_go  = req_val && req_rdy;
  assign w_resp_go = resp_val && resp_rdy;
  assign w_b_zero  = (r_b == '0);

  // ---------------------------------------------------------------- control
  always_comb begin
    w_state_next = r_state;
    w_a_sel      = A_SEL_HOLD;
    w_b_sel      = B_SEL_HOLD;
    w_res_sel    = RES_SEL_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (w_req_go) begin
          w_state_next = ST_CALC;
          w_a_sel      = A_SEL_LOAD;
          w_b_sel      = B_SEL_LOAD;
          w_res_sel    = RES_SEL_CLEAR;
        end
      end
      ST_CALC: begin
        if (w_b_zero) begin
          w_state_next = ST_DONE;
        end else begin
          w_a_sel = A_SEL_SHIFT;
          w_b_sel = B_SEL_SHIFT;
          if (r_b[0]) w_res_sel = RES_SEL_ADD;
        end
      end
      ST_DONE: begin
        if (w_resp_go) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------- datapath
  // Magnitudes are taken in NBITS unsigned arithmetic, so the most negative
  // value maps to 2^(NBITS-1) without overflow.
  assign w_a_neg = req_msg_signed && req_msg_a[NBITS-1];
  assign w_b_neg = req_msg_signed && req_msg_b[NBITS-1];
  assign w_a_mag = w_a_neg ? (~req_msg_a + NBITS'(1)) : req_msg_a;
  assign w_b_mag = w_b_neg ? (~req_msg_b + NBITS'(1)) : req_msg_b;

  int_mul_ctz_cap #(
    .NBITS     (NBITS),
    .SKIP_BITS (SKIP_BITS)
  ) u_ctz (
    .vec   (r_b),
    .count (w_ctz)
  );

  // An odd multiplier consumes exactly one bit together with the add;
  // otherwise a run of zeros (bounded by SKIP_BITS) is skipped.
  assign w_shamt = r_b[0] ? CW'(1) : w_ctz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
    end else begin
      case (w_a_sel)
        A_SEL_LOAD:  r_a <= {{NBITS{1'b0}}, w_a_mag};
        A_SEL_SHIFT: r_a <= r_a << w_shamt;
        default:     r_a <= r_a;
      endcase
      case (w_b_sel)
        B_SEL_LOAD:  r_b <= w_b_mag;
        B_SEL_SHIFT: r_b <= r_b >> w_shamt;
        default:     r_b <= r_b;
      endcase
      case (w_res_sel)
        RES_SEL_CLEAR: r_result <= '0;
        RES_SEL_ADD:   r_result <= r_result + r_a;
        default:       r_result <= r_result;
      endcase
      if (w_req_go) begin
        r_neg <= req_msg_signed && (req_msg_a[NBITS-1] ^ req_msg_b[NBITS-1]);
        r_hi  <= req_msg_hi;
      end
    end
  end

  // ------------------------------------------------------------------ output
  assign w_final  = r_neg ? (~r_result + (2*NBITS)'(1)) : r_result;
  assign resp_msg = r_hi ? w_final[2*NBITS-1:NBITS] : w_final[NBITS-1:0];

endmodule
`default_nettype wire
